// File: rtl/fanin_pkg.sv
// rtl/fanin_pkg.sv - shared types and helpers for the fan-in merge arbiter
package fanin_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } fanin_state_t;

    localparam int MAX_FANIN = 16;
    localparam int MAX_IDX_W = $clog2(MAX_FANIN);

    // Next round-robin start position after index idx, wrapping at n
    function automatic logic [MAX_IDX_W-1:0] rr_next(input logic [MAX_IDX_W-1:0] idx,
                                                     input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search from ptr with wrap
module rr_arbiter #(
    parameter int N     = 6,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;
    int   pos;

    // First requester found walking upward from ptr, modulo N, wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (en && !found && req[pos]) begin
                found      = 1'b1;
                gnt[pos]   = 1'b1;
                gnt_idx    = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/fanin_merge_arbiter.sv
// rtl/fanin_merge_arbiter.sv - merges NUM_IN streams into one registered output
module fanin_merge_arbiter
    import fanin_pkg::*;
#(
    parameter int NUM_IN = 6,
    parameter int DATA_W = 16,
    parameter int SRC_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [NUM_IN-1:0]        cfg_en,
    input  logic                     cfg_lock,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SRC_W-1:0]         out_src
);

    localparam int IDX_W = $clog2(NUM_IN);

    fanin_state_t      state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;

    logic [NUM_IN-1:0] req, req_arb, lock_mask, gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              load, arb_en, lock_active, xfer;

    // Lock only pins the grant while its owner stays enabled; disabling it abandons the packet
    assign req         = in_valid & cfg_en;
    assign lock_active = (state_q == LOCKED) && cfg_en[lock_idx_q];
    assign lock_mask   = lock_active ? (NUM_IN'(1) << lock_idx_q) : '1;
    assign req_arb     = req & lock_mask;
    assign load        = ~out_valid_q | out_ready;
    assign arb_en      = rst_n & ~clr & load;

    rr_arbiter #(.N(NUM_IN), .IDX_W(IDX_W)) u_arb (
        .req     (req_arb),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // A grant bit is only ever raised on a valid, enabled input, so any grant is a transfer
    assign in_ready = gnt;
    assign xfer     = |gnt;

    // Next-state: output register capture, pointer advance and packet-lock tracking
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (clr) begin
            state_d     = IDLE;
            rr_ptr_d    = '0;
            lock_idx_d  = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            out_src_d   = '0;
        end else begin
            if (load) begin
                out_valid_d = xfer;
                if (xfer) begin
                    out_data_d = in_data[int'(gnt_idx)*DATA_W +: DATA_W];
                    out_last_d = in_last[gnt_idx];
                    out_src_d  = SRC_W'(gnt_idx);
                    rr_ptr_d   = IDX_W'(rr_next(MAX_IDX_W'(gnt_idx), NUM_IN));
                    lock_idx_d = gnt_idx;
                end
            end
            if (xfer) begin
                state_d = (cfg_lock && !in_last[gnt_idx]) ? LOCKED : IDLE;
            end else if (!cfg_lock || !lock_active) begin
                state_d = IDLE;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_idx_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_idx_q  <= lock_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_fanin_merge_arbiter.sv
// tb/tb_fanin_merge_arbiter.sv - self-checking bench for fanin_merge_arbiter
module tb_fanin_merge_arbiter;

    localparam int N  = 6;
    localparam int DW = 16;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n, clr, cfg_lock, out_ready;
    logic [N-1:0]    cfg_en, in_valid, in_ready, in_last;
    logic [N*DW-1:0] in_data;
    logic            out_valid, out_last;
    logic [DW-1:0]   out_data;
    logic [SW-1:0]   out_src;

    fanin_merge_arbiter #(.NUM_IN(N), .DATA_W(DW), .SRC_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .cfg_en    (cfg_en),
        .cfg_lock  (cfg_lock),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: output slot, rotating start pointer, packet ownership
    int            m_ptr, m_lidx, m_os;
    bit            m_locked, m_ov, m_ol;
    logic [DW-1:0] m_od;

    function automatic void m_reset();
        m_ptr = 0; m_lidx = 0; m_os = 0;
        m_locked = 0; m_ov = 0; m_ol = 0; m_od = '0;
    endfunction

    function automatic logic [DW-1:0] beat(input int i);
        return in_data[i*DW +: DW];
    endfunction

    function automatic int m_winner();
        bit owned;
        int i;
        if (!rst_n || clr || !(!m_ov || out_ready)) return -1;
        owned = m_locked && cfg_en[m_lidx];
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (in_valid[i] && cfg_en[i] && (!owned || i == m_lidx)) return i;
        end
        return -1;
    endfunction

    function automatic void m_update(input int w);
        if (!rst_n || clr) begin
            m_reset();
            return;
        end
        if (w >= 0) begin
            m_ov = 1; m_od = beat(w); m_ol = in_last[w]; m_os = w;
            m_ptr = (w + 1) % N;
            m_locked = cfg_lock && !in_last[w];
            m_lidx = w;
        end else begin
            if (!m_ov || out_ready) m_ov = 0;
            if (!cfg_lock || (m_locked && !cfg_en[m_lidx])) m_locked = 0;
        end
    endfunction

    task automatic settle();
        int w;
        logic [31:0] e;
        #1;
        w = m_winner();
        e = (w >= 0) ? (32'd1 << w) : 32'd0;
        chk("in_ready", 32'(in_ready), e);
    endtask

    task automatic clock_edge();
        int w;
        w = m_winner();
        @(posedge clk);
        #1;
        m_update(w);
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data", 32'(out_data), 32'(m_od));
        chk("out_last", 32'(out_last), 32'(m_ol));
        chk("out_src", 32'(out_src), 32'(m_os));
    endtask

    typedef struct {
        logic [N-1:0] v, en, last;
        logic         lock, ordy;
        logic [N-1:0] rdy;
        logic         ov;
        int           src;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [N-1:0] v, en, last, input logic lock, ordy,
                                input logic [N-1:0] rdy, input logic ov, input int src);
        vec_t t;
        t.v = v; t.en = en; t.last = last; t.lock = lock; t.ordy = ordy;
        t.rdy = rdy; t.ov = ov; t.src = src;
        vq.push_back(t);
    endfunction

    initial begin
        rst_n = 1'b0; clr = 1'b0; cfg_lock = 1'b0; out_ready = 1'b1;
        cfg_en = 6'h3F; in_valid = 6'h3F; in_last = '0;
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 16'(16'h1111 * (i + 1));
        m_reset();

        // Round-robin over all inputs
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h01, 1, 0);
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h02, 1, 1);
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h04, 1, 2);
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h08, 1, 3);
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h10, 1, 4);
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h20, 1, 5);
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h01, 1, 0);
        // Backpressure holds the slot, then the next beat follows with no bubble
        add(6'h3F, 6'h3F, 6'h00, 0, 0, 6'h00, 1, 0);
        add(6'h3F, 6'h3F, 6'h00, 0, 0, 6'h00, 1, 0);
        add(6'h3F, 6'h3F, 6'h00, 0, 0, 6'h00, 1, 0);
        add(6'h3F, 6'h3F, 6'h00, 0, 1, 6'h02, 1, 1);
        // Input 3 disabled while valid
        add(6'h3F, 6'h37, 6'h00, 0, 1, 6'h04, 1, 2);
        add(6'h3F, 6'h37, 6'h00, 0, 1, 6'h10, 1, 4);
        add(6'h3F, 6'h37, 6'h00, 0, 1, 6'h20, 1, 5);
        add(6'h3F, 6'h37, 6'h00, 0, 1, 6'h01, 1, 0);
        add(6'h3F, 6'h37, 6'h00, 0, 1, 6'h02, 1, 1);
        add(6'h3F, 6'h37, 6'h00, 0, 1, 6'h04, 1, 2);
        add(6'h3F, 6'h37, 6'h00, 0, 1, 6'h10, 1, 4);
        // Wrap from 5 to 0
        add(6'h21, 6'h3F, 6'h00, 0, 1, 6'h20, 1, 5);
        add(6'h21, 6'h3F, 6'h00, 0, 1, 6'h01, 1, 0);
        // Locked 3-beat packet on input 2, input 4 waits
        add(6'h14, 6'h3F, 6'h10, 1, 1, 6'h04, 1, 2);
        add(6'h14, 6'h3F, 6'h10, 1, 1, 6'h04, 1, 2);
        add(6'h14, 6'h3F, 6'h14, 1, 1, 6'h04, 1, 2);
        add(6'h14, 6'h3F, 6'h10, 1, 1, 6'h10, 1, 4);
        // Unlocked: interleave
        add(6'h14, 6'h3F, 6'h10, 0, 1, 6'h04, 1, 2);
        add(6'h14, 6'h3F, 6'h10, 0, 1, 6'h10, 1, 4);
        add(6'h14, 6'h3F, 6'h10, 0, 1, 6'h04, 1, 2);
        add(6'h14, 6'h3F, 6'h10, 0, 1, 6'h10, 1, 4);
        add(6'h00, 6'h3F, 6'h00, 0, 1, 6'h00, 0, 0);

        // Reset with every input valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[r]) begin
            in_valid = vq[r].v; cfg_en = vq[r].en; in_last = vq[r].last;
            cfg_lock = vq[r].lock; out_ready = vq[r].ordy;
            settle();
            chk($sformatf("tbl%0d_rdy", r), 32'(in_ready), 32'(vq[r].rdy));
            clock_edge();
            chk($sformatf("tbl%0d_ov", r), 32'(out_valid), 32'(vq[r].ov));
            if (vq[r].ov) begin
                chk($sformatf("tbl%0d_src", r), 32'(out_src), 32'(vq[r].src));
                chk($sformatf("tbl%0d_data", r), 32'(out_data), 32'(16'h1111 * (vq[r].src + 1)));
            end
            @(negedge clk);
        end

        // Stalled output holds 16'hBEEF, next beat follows release
        cfg_en = 6'h3F; cfg_lock = 0; in_last = '0; out_ready = 1;
        in_valid = 6'h01; in_data[0 +: DW] = 16'hBEEF;
        settle();
        chk("beef_rdy", 32'(in_ready), 32'h01);
        clock_edge();
        chk("beef_cap", 32'(out_data), 32'hBEEF);
        @(negedge clk);
        in_valid = 6'h02; in_data[DW +: DW] = 16'h1234; out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("stall_rdy", 32'(in_ready), 32'd0);
            clock_edge();
            chk("stall_data", 32'(out_data), 32'hBEEF);
            chk("stall_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1;
        settle();
        chk("drain_rdy", 32'(in_ready), 32'h02);
        clock_edge();
        chk("drain_data", 32'(out_data), 32'h1234);
        chk("drain_src", 32'(out_src), 32'd1);
        @(negedge clk);

        // Lock on input 3, then flush mid-packet
        cfg_lock = 1; in_valid = 6'h08; in_last = '0;
        settle();
        chk("lk_first", 32'(in_ready), 32'h08);
        clock_edge();
        @(negedge clk);
        in_valid = 6'h09;
        settle();
        chk("lk_hold", 32'(in_ready), 32'h08);
        clock_edge();
        @(negedge clk);
        clr = 1;
        settle();
        chk("clr_rdy", 32'(in_ready), 32'd0);
        clock_edge();
        chk("clr_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        clr = 0; cfg_lock = 0; in_valid = 6'h3F;
        settle();
        chk("post_clr_rdy", 32'(in_ready), 32'h01);
        clock_edge();
        @(negedge clk);

        // Randomised traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            in_valid  = N'($urandom);
            in_last   = N'($urandom);
            cfg_en    = ($urandom_range(0, 7) == 0) ? N'($urandom) : 6'h3F;
            out_ready = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 63) == 0);
            if (c % 200 == 0) cfg_lock = $urandom_range(0, 1);
            for (int i = 0; i < N; i++) in_data[i*DW +: DW] = DW'($urandom);
            settle();
            clock_edge();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
